// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one variable-latency memory port between the
// fetch (imem) and load/store (dmem) requesters, with one transaction in flight.
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        freeze_stall,
  output logic        timeout_err
);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {GNT_I, GNT_D} gnt_t;

  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  gnt_t        last_q, owner_q, grant;
  logic        i_pend_q, i_pend_d, d_pend_q, d_pend_d;
  logic [7:0]  wd_q, wd_d;
  logic        timeout_q;

  logic [31:0] i_addr_q, d_addr_q, d_wdata_q;
  logic [3:0]  i_rmask_q, d_rmask_q, d_wmask_q;

  logic        issue, resp_ok, tmo, done;
  logic        i_req, d_req, i_acc, d_acc, i_clr, d_clr;

  // Request capture: a port may re-request in the cycle its transaction completes.
  always_comb begin
    i_req = (imem_rmask != 4'h0);
    d_req = ((dmem_rmask | dmem_wmask) != 4'h0);
    i_acc = i_req && (!i_pend_q || i_clr);
    d_acc = d_req && (!d_pend_q || d_clr);
    i_pend_d = i_acc ? 1'b1 : (i_clr ? 1'b0 : i_pend_q);
    d_pend_d = d_acc ? 1'b1 : (d_clr ? 1'b0 : d_pend_q);
  end

  always_ff @(posedge clk) begin
    if (i_acc) begin
      i_addr_q  <= imem_addr;
      i_rmask_q <= imem_rmask;
    end
    if (d_acc) begin
      d_addr_q  <= dmem_addr;
      d_wmask_q <= dmem_wmask;
      d_rmask_q <= (dmem_wmask != 4'h0) ? 4'h0 : dmem_rmask;
      d_wdata_q <= dmem_wdata;
    end
  end

  // Grant and completion decode from registered state.
  always_comb begin
    issue   = (state_q == IDLE) && (i_pend_q || d_pend_q);
    grant   = (d_pend_q && (!i_pend_q || last_q == GNT_I)) ? GNT_D : GNT_I;
    resp_ok = (state_q == WAIT) && mem_resp;
    tmo     = (state_q == WAIT) && !mem_resp && (wd_q == WD_LAST);
    done    = resp_ok || tmo;
    i_clr   = done && (owner_q == GNT_I);
    d_clr   = done && (owner_q == GNT_D);
    wd_d    = ((state_q == WAIT) && !done) ? wd_q + 8'd1 : 8'd0;
  end

  always_comb begin
    mem_addr  = 32'h0;
    mem_rmask = 4'h0;
    mem_wmask = 4'h0;
    mem_wdata = 32'h0;
    if (issue) begin
      if (grant == GNT_D) begin
        mem_addr  = d_addr_q;
        mem_rmask = d_rmask_q;
        mem_wmask = d_wmask_q;
        mem_wdata = d_wdata_q;
      end else begin
        mem_addr  = i_addr_q;
        mem_rmask = i_rmask_q;
      end
    end
  end

  always_comb begin
    imem_resp    = i_clr;
    dmem_resp    = d_clr;
    imem_rdata   = (resp_ok && owner_q == GNT_I) ? mem_rdata : 32'h0;
    dmem_rdata   = (resp_ok && owner_q == GNT_D) ? mem_rdata : 32'h0;
    freeze_stall = i_pend_q || d_pend_q || (state_q == WAIT);
    timeout_err  = timeout_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      last_q    <= GNT_I;
      owner_q   <= GNT_I;
      i_pend_q  <= 1'b0;
      d_pend_q  <= 1'b0;
      wd_q      <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      i_pend_q <= i_pend_d;
      d_pend_q <= d_pend_d;
      wd_q     <= wd_d;
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_q <= WAIT;
            owner_q <= grant;
            last_q  <= grant;
          end
        end
        WAIT: begin
          if (tmo) timeout_q <= 1'b1;
          if (done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; the bench plays the backing memory cycle by cycle.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] imem_addr = '0, dmem_addr = '0, dmem_wdata = '0, mem_rdata = '0;
  logic [3:0]  imem_rmask = '0, dmem_rmask = '0, dmem_wmask = '0;
  logic        mem_resp = 1'b0;
  logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_rmask, mem_wmask;
  logic        imem_resp, dmem_resp, freeze_stall, timeout_err;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask), .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .freeze_stall(freeze_stall), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Advance to the next cycle and return all pulse inputs to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    imem_rmask = 4'h0;
    dmem_rmask = 4'h0;
    dmem_wmask = 4'h0;
    mem_resp   = 1'b0;
    mem_rdata  = 32'h0;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    #1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc();
    #1;
    chk("rst_freeze", {31'h0, freeze_stall}, 32'h0);
    chk("rst_mem_rmask", {28'h0, mem_rmask}, 32'h0);
    chk("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_resp", {30'h0, imem_resp, dmem_resp}, 32'h0);
    chk("rst_rdata", imem_rdata | dmem_rdata, 32'h0);
    chk("rst_timeout", {31'h0, timeout_err}, 32'h0);
    rst = 1'b0;

    // Single fetch, latency 3; duplicate request during WAIT is ignored
    cyc(); imem_addr = 32'h6000_0000; imem_rmask = 4'hF; #1;
    chk("f_c0_freeze", {31'h0, freeze_stall}, 32'h0);
    chk("f_c0_rmask", {28'h0, mem_rmask}, 32'h0);
    cyc(); #1;
    chk("f_c1_rmask", {28'h0, mem_rmask}, 32'hF);
    chk("f_c1_addr", mem_addr, 32'h6000_0000);
    chk("f_c1_freeze", {31'h0, freeze_stall}, 32'h1);
    cyc(); imem_addr = 32'h7777_0000; imem_rmask = 4'hF; #1;
    chk("f_c2_rmask", {28'h0, mem_rmask}, 32'h0);
    chk("f_c2_resp", {31'h0, imem_resp}, 32'h0);
    cyc(); #1;
    cyc(); mem_resp = 1'b1; mem_rdata = 32'h0000_0013; #1;
    chk("f_c4_iresp", {31'h0, imem_resp}, 32'h1);
    chk("f_c4_irdata", imem_rdata, 32'h0000_0013);
    chk("f_c4_dresp", {31'h0, dmem_resp}, 32'h0);
    cyc(); #1;
    chk("f_c5_freeze", {31'h0, freeze_stall}, 32'h0);
    chk("f_c5_iresp", {31'h0, imem_resp}, 32'h0);
    chk("f_c5_rmask", {28'h0, mem_rmask}, 32'h0);

    // Conflict right after reset: dmem first, then imem
    do_reset();
    cyc(); imem_addr = 32'h0000_0100; imem_rmask = 4'hF;
    dmem_addr = 32'h0000_2000; dmem_rmask = 4'h3; #1;
    cyc(); #1;
    chk("c_d_addr", mem_addr, 32'h0000_2000);
    chk("c_d_rmask", {28'h0, mem_rmask}, 32'h3);
    cyc(); mem_resp = 1'b1; mem_rdata = 32'hAAAA_5555; #1;
    chk("c_d_resp", {30'h0, imem_resp, dmem_resp}, 32'h1);
    chk("c_d_rdata", dmem_rdata, 32'hAAAA_5555);
    chk("c_i_rdata_idle", imem_rdata, 32'h0);
    cyc(); #1;
    chk("c_i_addr", mem_addr, 32'h0000_0100);
    chk("c_i_rmask", {28'h0, mem_rmask}, 32'hF);
    chk("c_i_freeze", {31'h0, freeze_stall}, 32'h1);
    cyc(); mem_resp = 1'b1; mem_rdata = 32'h1111_2222; #1;
    chk("c_i_resp", {30'h0, imem_resp, dmem_resp}, 32'h2);
    chk("c_i_rdata", imem_rdata, 32'h1111_2222);
    cyc(); #1;
    chk("c_end_freeze", {31'h0, freeze_stall}, 32'h0);

    // Store with simultaneous rmask: store wins
    cyc(); dmem_addr = 32'h0000_1004; dmem_wmask = 4'b0011; dmem_rmask = 4'hF;
    dmem_wdata = 32'hDEAD_BEEF; #1;
    cyc(); #1;
    chk("s_wmask", {28'h0, mem_wmask}, 32'h3);
    chk("s_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk("s_rmask", {28'h0, mem_rmask}, 32'h0);
    chk("s_addr", mem_addr, 32'h0000_1004);
    cyc(); #1;
    chk("s_wmask_wait", {28'h0, mem_wmask}, 32'h0);
    cyc(); mem_resp = 1'b1; mem_rdata = 32'h0000_0055; #1;
    chk("s_resp", {30'h0, imem_resp, dmem_resp}, 32'h1);
    chk("s_rdata", dmem_rdata, 32'h0000_0055);
    cyc(); #1;
    chk("s_end_freeze", {31'h0, freeze_stall}, 32'h0);

    // Sustained contention (last grant was dmem): I,D,I,D,... then drain
    imem_addr = 32'h0000_3000;
    dmem_addr = 32'h0000_4000;
    cyc(); imem_rmask = 4'hF; dmem_rmask = 4'hF; #1;
    for (int k = 0; k < 8; k++) begin
      cyc(); #1;
      chk($sformatf("rr%0d_addr", k), mem_addr, (k % 2 == 0) ? 32'h0000_3000 : 32'h0000_4000);
      cyc(); mem_resp = 1'b1; mem_rdata = 32'hC0DE_0000 + k;
      if (k < 6) begin
        imem_rmask = 4'hF;
        dmem_rmask = 4'hF;
      end
      #1;
      chk($sformatf("rr%0d_resp", k), {30'h0, imem_resp, dmem_resp},
          (k % 2 == 0) ? 32'h2 : 32'h1);
    end
    cyc(); #1;
    chk("rr_end_freeze", {31'h0, freeze_stall}, 32'h0);

    // Watchdog with TIMEOUT_CYCLES=8
    cyc(); imem_addr = 32'h0000_5000; imem_rmask = 4'hF; #1;
    cyc(); #1;
    chk("w_issue", {28'h0, mem_rmask}, 32'hF);
    for (int w = 1; w < 8; w++) begin
      cyc(); mem_rdata = 32'hFFFF_FFFF; #1;
      chk($sformatf("w_wait%0d", w), {31'h0, imem_resp}, 32'h0);
    end
    cyc(); mem_rdata = 32'hFFFF_FFFF; #1;
    chk("w_resp", {31'h0, imem_resp}, 32'h1);
    chk("w_rdata", imem_rdata, 32'h0);
    chk("w_err_pre", {31'h0, timeout_err}, 32'h0);
    cyc(); #1;
    chk("w_err", {31'h0, timeout_err}, 32'h1);
    chk("w_freeze", {31'h0, freeze_stall}, 32'h0);
    cyc(); mem_resp = 1'b1; mem_rdata = 32'h1234_5678; #1;
    chk("w_stale", {30'h0, imem_resp, dmem_resp}, 32'h0);
    cyc(); #1;
    chk("w_sticky", {31'h0, timeout_err}, 32'h1);

    // Reset mid-WAIT
    cyc(); imem_addr = 32'h0000_6000; imem_rmask = 4'hF; #1;
    cyc(); #1;
    cyc(); #1;
    chk("r_inflight", {31'h0, freeze_stall}, 32'h1);
    rst = 1'b1; mem_resp = 1'b1; mem_rdata = 32'h9999_9999; #1;
    chk("r_freeze", {31'h0, freeze_stall}, 32'h0);
    chk("r_err", {31'h0, timeout_err}, 32'h0);
    chk("r_resp", {31'h0, imem_resp}, 32'h0);
    chk("r_rdata", imem_rdata, 32'h0);
    cyc(); rst = 1'b0; #1;
    cyc(); mem_resp = 1'b1; mem_rdata = 32'h9999_9999; #1;
    chk("r_stale", {30'h0, imem_resp, dmem_resp}, 32'h0);
    chk("r_stale_rmask", {28'h0, mem_rmask}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
